adc_5g_phase_cal: RTL and testbench



---
 rtl/adc_5g_cal_pkg.sv | 29 ++
 rtl/adc_5g_window_track.sv | 48 ++++
 rtl/adc_5g_phase_cal.sv | 217 +++++++++++++++++++++
 tb/tb_adc_5g_phase_cal.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_5g_cal_pkg.sv
// Shared state encoding and default tuning constants for the ADC capture
// phase calibration sequencer.
package adc_5g_cal_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST,
    S_WAIT_LOCK,
    S_DWELL,
    S_STEP,
    S_WAIT_PS,
    S_EVAL,
    S_RET_STEP,
    S_RET_WAIT,
    S_DONE,
    S_FAIL
  } cal_state_e;

  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_LOCK_TIMEOUT = 65535;
  localparam int DEF_DWELL        = 256;
  localparam int DEF_MAX_STEPS    = 255;
  localparam int DEF_PS_TIMEOUT   = 1023;
  localparam int DEF_STEP_W       = 8;

  // One shared wait/dwell counter; must hold the largest timeout.
  localparam int CNT_W = 16;

endpackage

// File: rtl/adc_5g_window_track.sv
// Tracks runs of passing phase positions and keeps the widest one seen;
// a later run must be strictly longer to replace it, so the earliest wins ties.
module adc_5g_window_track
  import adc_5g_cal_pkg::*;
#(
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              valid,
  input  logic              good,
  input  logic [STEP_W-1:0] pos,
  output logic [STEP_W-1:0] best_start,
  output logic [STEP_W:0]   best_len
);

  logic [STEP_W-1:0] run_start;
  logic [STEP_W-1:0] run_start_nxt;
  logic [STEP_W:0]   run_len;
  logic [STEP_W:0]   run_len_nxt;

  always_comb begin
    run_start_nxt = (run_len == '0) ? pos : run_start;
    run_len_nxt   = run_len + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (valid) begin
      if (good) begin
        run_start <= run_start_nxt;
        run_len   <= run_len_nxt;
        if (run_len_nxt > best_len) begin
          best_start <= run_start_nxt;
          best_len   <= run_len_nxt;
        end
      end else begin
        run_len <= '0;
      end
    end
  end

endmodule

// File: rtl/adc_5g_phase_cal.sv
// Calibration sequencer: resets the capture DCM, sweeps its phase shift,
// finds the widest passing window and steps back to the window centre.
module adc_5g_phase_cal
  import adc_5g_cal_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int DWELL        = DEF_DWELL,
  parameter int MAX_STEPS    = DEF_MAX_STEPS,
  parameter int PS_TIMEOUT   = DEF_PS_TIMEOUT,
  parameter int STEP_W       = DEF_STEP_W
) (
  input  logic              ctrl_clk,
  input  logic              ctrl_rst_n,
  input  logic              cal_start,
  input  logic              dcm_locked,
  input  logic              pattern_ok,
  input  logic              dcm_psdone,
  output logic              dcm_reset,
  output logic              dcm_psen,
  output logic              dcm_psincdec,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_fail,
  output logic [STEP_W-1:0] cal_phase,
  output logic [STEP_W:0]   win_len
);

  cal_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [STEP_W-1:0] pos, pos_nxt;
  logic [STEP_W-1:0] ret, ret_nxt;
  logic              bad, bad_nxt;
  logic              incdec_q;
  logic              done_nxt, fail_nxt;
  logic [STEP_W-1:0] phase_nxt;
  logic [STEP_W:0]   wlen_nxt;
  logic              trk_clear, trk_valid, trk_good;
  logic [STEP_W-1:0] best_start;
  logic [STEP_W:0]   best_len;
  logic [STEP_W-1:0] centre;
  logic              in_sweep;

  adc_5g_window_track #(
    .STEP_W(STEP_W)
  ) u_track (
    .clk       (ctrl_clk),
    .rst_n     (ctrl_rst_n),
    .clear     (trk_clear),
    .valid     (trk_valid),
    .good      (trk_good),
    .pos       (pos),
    .best_start(best_start),
    .best_len  (best_len)
  );

  assign centre = best_start + STEP_W'(best_len >> 1);

  assign in_sweep = (state == S_DWELL)    || (state == S_STEP)     ||
                    (state == S_WAIT_PS)  || (state == S_EVAL)     ||
                    (state == S_RET_STEP) || (state == S_RET_WAIT);

  // Phase-step waits count from the psen cycle itself, so a step that never
  // completes fails exactly PS_TIMEOUT cycles after its pulse.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt + 1'b1;
    pos_nxt      = pos;
    ret_nxt      = ret;
    bad_nxt      = bad;
    done_nxt     = cal_done;
    fail_nxt     = cal_fail;
    phase_nxt    = cal_phase;
    wlen_nxt     = win_len;
    trk_clear    = 1'b0;
    trk_valid    = 1'b0;
    trk_good     = 1'b0;
    dcm_reset    = 1'b0;
    dcm_psen     = 1'b0;
    dcm_psincdec = incdec_q;
    cal_busy     = (state != S_IDLE);

    if (in_sweep && !dcm_locked) begin
      state_nxt = S_FAIL;
      fail_nxt  = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          cnt_nxt = '0;
          if (cal_start) begin
            state_nxt = S_RST;
            done_nxt  = 1'b0;
            fail_nxt  = 1'b0;
            phase_nxt = '0;
            wlen_nxt  = '0;
            trk_clear = 1'b1;
          end
        end
        S_RST: begin
          dcm_reset = 1'b1;
          if (cnt == CNT_W'(RST_CYCLES - 1)) begin
            state_nxt = S_WAIT_LOCK;
            cnt_nxt   = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (dcm_locked) begin
            state_nxt = S_DWELL;
            pos_nxt   = '0;
            cnt_nxt   = '0;
            bad_nxt   = 1'b0;
          end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            state_nxt = S_FAIL;
            fail_nxt  = 1'b1;
          end
        end
        S_DWELL: begin
          bad_nxt = bad | ~pattern_ok;
          if (cnt == CNT_W'(DWELL - 1)) begin
            trk_valid = 1'b1;
            trk_good  = ~bad & pattern_ok;
            state_nxt = (pos == STEP_W'(MAX_STEPS)) ? S_EVAL : S_STEP;
          end
        end
        S_STEP: begin
          dcm_psen     = 1'b1;
          dcm_psincdec = 1'b1;
          state_nxt    = S_WAIT_PS;
          cnt_nxt      = CNT_W'(1);
        end
        S_WAIT_PS: begin
          if (dcm_psdone) begin
            pos_nxt   = pos + 1'b1;
            state_nxt = S_DWELL;
            cnt_nxt   = '0;
            bad_nxt   = 1'b0;
          end else if (cnt == CNT_W'(PS_TIMEOUT - 1)) begin
            state_nxt = S_FAIL;
            fail_nxt  = 1'b1;
          end
        end
        S_EVAL: begin
          wlen_nxt = best_len;
          if (best_len == '0) begin
            state_nxt = S_FAIL;
            fail_nxt  = 1'b1;
          end else begin
            phase_nxt = centre;
            ret_nxt   = STEP_W'(MAX_STEPS) - centre;
            if (ret_nxt == '0) begin
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = S_RET_STEP;
            end
          end
        end
        S_RET_STEP: begin
          dcm_psen     = 1'b1;
          dcm_psincdec = 1'b0;
          state_nxt    = S_RET_WAIT;
          cnt_nxt      = CNT_W'(1);
        end
        S_RET_WAIT: begin
          if (dcm_psdone) begin
            ret_nxt = ret - 1'b1;
            if (ret == STEP_W'(1)) begin
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = S_RET_STEP;
            end
          end else if (cnt == CNT_W'(PS_TIMEOUT - 1)) begin
            state_nxt = S_FAIL;
            fail_nxt  = 1'b1;
          end
        end
        S_DONE: begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
        S_FAIL: begin
          fail_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ctrl_clk) begin
    if (!ctrl_rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pos       <= '0;
      ret       <= '0;
      bad       <= 1'b0;
      incdec_q  <= 1'b0;
      cal_done  <= 1'b0;
      cal_fail  <= 1'b0;
      cal_phase <= '0;
      win_len   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pos       <= pos_nxt;
      ret       <= ret_nxt;
      bad       <= bad_nxt;
      incdec_q  <= dcm_psincdec;
      cal_done  <= done_nxt;
      cal_fail  <= fail_nxt;
      cal_phase <= phase_nxt;
      win_len   <= wlen_nxt;
    end
  end

endmodule

// File: tb/tb_adc_5g_phase_cal.sv
// Directed bench for adc_5g_phase_cal with a small behavioural DCM model
// that answers phase steps, tracks its phase and drives the test pattern.
module tb_adc_5g_phase_cal;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 65535;
  localparam int DWELL        = 4;
  localparam int MAX_STEPS    = 15;
  localparam int PS_TIMEOUT   = 31;
  localparam int STEP_W       = 8;
  localparam int RUN_BOUND    = 70000;

  logic              ctrl_clk = 1'b0;
  logic              ctrl_rst_n;
  logic              cal_start;
  logic              dcm_locked;
  logic              pattern_ok;
  logic              dcm_psdone;
  logic              dcm_reset;
  logic              dcm_psen;
  logic              dcm_psincdec;
  logic              cal_busy;
  logic              cal_done;
  logic              cal_fail;
  logic [STEP_W-1:0] cal_phase;
  logic [STEP_W:0]   win_len;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [15:0] pat_mask    = 16'h0000;
  bit          glitch_en   = 1'b0;
  bit          withhold    = 1'b0;
  bit          force_unlock = 1'b0;

  int  mpos      = 0;
  bit  mlocked   = 1'b0;
  int  lock_cnt  = 0;
  bit  pend      = 1'b0;
  int  pdelay    = 0;
  bit  pdir      = 1'b0;
  int  cyc_at_pos = 0;
  int  inc_cnt   = 0;
  int  dec_cnt   = 0;
  int  rst_cnt   = 0;

  int run_inc, run_dec, run_rst;

  always #5 ctrl_clk = ~ctrl_clk;

  adc_5g_phase_cal #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .DWELL       (DWELL),
    .MAX_STEPS   (MAX_STEPS),
    .PS_TIMEOUT  (PS_TIMEOUT),
    .STEP_W      (STEP_W)
  ) dut (
    .ctrl_clk    (ctrl_clk),
    .ctrl_rst_n  (ctrl_rst_n),
    .cal_start   (cal_start),
    .dcm_locked  (dcm_locked),
    .pattern_ok  (pattern_ok),
    .dcm_psdone  (dcm_psdone),
    .dcm_reset   (dcm_reset),
    .dcm_psen    (dcm_psen),
    .dcm_psincdec(dcm_psincdec),
    .cal_busy    (cal_busy),
    .cal_done    (cal_done),
    .cal_fail    (cal_fail),
    .cal_phase   (cal_phase),
    .win_len     (win_len)
  );

  // DCM model: locks 10 cycles after its reset drops, completes each phase
  // step three cycles after the psen pulse, and serves pattern_ok per phase.
  always @(negedge ctrl_clk) begin
    dcm_psdone = 1'b0;
    cyc_at_pos++;
    if (dcm_reset) begin
      pend     = 1'b0;
      mpos     = 0;
      mlocked  = 1'b0;
      lock_cnt = 0;
      rst_cnt++;
    end else begin
      if (!mlocked) begin
        lock_cnt++;
        if (lock_cnt >= 10) mlocked = 1'b1;
      end
      if (pend && !withhold) begin
        if (pdelay == 0) begin
          dcm_psdone = 1'b1;
          mpos       = pdir ? mpos + 1 : mpos - 1;
          cyc_at_pos = 0;
          pend       = 1'b0;
        end else begin
          pdelay--;
        end
      end
      if (dcm_psen) begin
        pend   = 1'b1;
        pdelay = 2;
        pdir   = dcm_psincdec;
        if (dcm_psincdec) inc_cnt++;
        else dec_cnt++;
      end
    end
    dcm_locked = mlocked && !force_unlock;
    pattern_ok = pat_mask[mpos[3:0]] && !(glitch_en && mpos == 7 && cyc_at_pos == 2);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic pulseStart();
    @(negedge ctrl_clk);
    cal_start = 1'b1;
    @(negedge ctrl_clk);
    cal_start = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (cal_busy && n < RUN_BOUND) begin
      @(negedge ctrl_clk);
      n++;
    end
    if (cal_busy) checkOutput({tag, "_idle_timeout"}, 32'd1, 32'd0);
    @(negedge ctrl_clk);
  endtask

  task automatic waitPsen(input string tag);
    int n;
    n = 0;
    while (!dcm_psen && n < 500) begin
      @(negedge ctrl_clk);
      n++;
    end
    if (!dcm_psen) checkOutput({tag, "_psen_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic applyStimulus(input logic [15:0] mask, input bit glitch);
    int inc0, dec0, rst0;
    pat_mask  = mask;
    glitch_en = glitch;
    inc0 = inc_cnt;
    dec0 = dec_cnt;
    rst0 = rst_cnt;
    pulseStart();
    waitIdle("run");
    run_inc = inc_cnt - inc0;
    run_dec = dec_cnt - dec0;
    run_rst = rst_cnt - rst0;
    glitch_en = 1'b0;
  endtask

  initial begin
    int k;
    ctrl_rst_n = 1'b0;
    cal_start  = 1'b0;
    dcm_locked = 1'b0;
    pattern_ok = 1'b0;
    dcm_psdone = 1'b0;
    repeat (3) @(negedge ctrl_clk);

    checkOutput("rst_busy",  32'(cal_busy),  32'd0);
    checkOutput("rst_done",  32'(cal_done),  32'd0);
    checkOutput("rst_fail",  32'(cal_fail),  32'd0);
    checkOutput("rst_phase", 32'(cal_phase), 32'd0);
    checkOutput("rst_win",   32'(win_len),   32'd0);
    checkOutput("rst_psen",  32'(dcm_psen),  32'd0);
    checkOutput("rst_dcmrst", 32'(dcm_reset), 32'd0);
    ctrl_rst_n = 1'b1;
    repeat (2) @(negedge ctrl_clk);

    // Window 5..9: centre 5 + 5/2 = 7, return 15 - 7 = 8 steps.
    applyStimulus(16'b0000_0011_1110_0000, 1'b0);
    checkOutput("w59_done",  32'(cal_done),  32'd1);
    checkOutput("w59_fail",  32'(cal_fail),  32'd0);
    checkOutput("w59_phase", 32'(cal_phase), 32'd7);
    checkOutput("w59_win",   32'(win_len),   32'd5);
    checkOutput("w59_inc",   32'(run_inc),   32'd15);
    checkOutput("w59_dec",   32'(run_dec),   32'd8);
    checkOutput("w59_rstcyc", 32'(run_rst),  32'(RST_CYCLES));
    checkOutput("w59_dcmpos", 32'(mpos),     32'd7);

    // Windows 2..3 and 10..13: longer one wins, centre 10 + 4/2 = 12.
    applyStimulus(16'b0011_1100_0000_1100, 1'b0);
    checkOutput("w2x_done",  32'(cal_done),  32'd1);
    checkOutput("w2x_phase", 32'(cal_phase), 32'd12);
    checkOutput("w2x_win",   32'(win_len),   32'd4);
    checkOutput("w2x_dec",   32'(run_dec),   32'd3);
    checkOutput("w2x_dcmpos", 32'(mpos),     32'd12);

    // Equal windows 1..3 and 8..10: earliest kept, centre 2, 13 steps back.
    applyStimulus(16'b0000_0111_0000_1110, 1'b0);
    checkOutput("tie_phase", 32'(cal_phase), 32'd2);
    checkOutput("tie_win",   32'(win_len),   32'd3);
    checkOutput("tie_dec",   32'(run_dec),   32'd13);
    checkOutput("tie_done",  32'(cal_done),  32'd1);

    // One bad cycle at position 7 splits 5..9 into 5..6 and 8..9; tie keeps 5..6.
    applyStimulus(16'b0000_0011_1110_0000, 1'b1);
    checkOutput("gl_phase", 32'(cal_phase), 32'd6);
    checkOutput("gl_win",   32'(win_len),   32'd2);
    checkOutput("gl_dec",   32'(run_dec),   32'd9);

    // Window at the very end 15..15: centre 15, no return steps.
    applyStimulus(16'b1000_0000_0000_0000, 1'b0);
    checkOutput("end_phase", 32'(cal_phase), 32'd15);
    checkOutput("end_win",   32'(win_len),   32'd1);
    checkOutput("end_dec",   32'(run_dec),   32'd0);
    checkOutput("end_done",  32'(cal_done),  32'd1);

    // No passing position at all.
    applyStimulus(16'h0000, 1'b0);
    checkOutput("none_fail",  32'(cal_fail),  32'd1);
    checkOutput("none_done",  32'(cal_done),  32'd0);
    checkOutput("none_win",   32'(win_len),   32'd0);
    checkOutput("none_phase", 32'(cal_phase), 32'd0);
    checkOutput("none_inc",   32'(run_inc),   32'd15);
    checkOutput("none_dec",   32'(run_dec),   32'd0);

    // Reset while waiting for the first phase step to complete.
    pat_mask = 16'b0000_0011_1110_0000;
    pulseStart();
    waitPsen("mid");
    @(negedge ctrl_clk);
    ctrl_rst_n = 1'b0;
    @(negedge ctrl_clk);
    checkOutput("mid_busy",  32'(cal_busy),  32'd0);
    checkOutput("mid_psen",  32'(dcm_psen),  32'd0);
    checkOutput("mid_dcmrst", 32'(dcm_reset), 32'd0);
    checkOutput("mid_done",  32'(cal_done),  32'd0);
    checkOutput("mid_fail",  32'(cal_fail),  32'd0);
    ctrl_rst_n = 1'b1;
    repeat (6) @(negedge ctrl_clk);
    applyStimulus(16'b0000_0011_1110_0000, 1'b0);
    checkOutput("mid_re_done",  32'(cal_done),  32'd1);
    checkOutput("mid_re_phase", 32'(cal_phase), 32'd7);
    checkOutput("mid_re_win",   32'(win_len),   32'd5);

    // Phase step never completes: fail PS_TIMEOUT cycles after the pulse.
    withhold = 1'b1;
    pulseStart();
    waitPsen("ps");
    k = 0;
    while (!cal_fail && k < 200) begin
      @(negedge ctrl_clk);
      k++;
    end
    checkOutput("ps_fail_lat", 32'(k), 32'(PS_TIMEOUT));
    checkOutput("ps_fail",     32'(cal_fail), 32'd1);
    waitIdle("ps");
    checkOutput("ps_done",     32'(cal_done), 32'd0);
    withhold = 1'b0;

    // DCM never locks: RST_CYCLES of reset, LOCK_TIMEOUT cycles of waiting.
    force_unlock = 1'b1;
    run_inc = inc_cnt;
    pulseStart();
    k = 1;
    while (!cal_fail && k < RUN_BOUND) begin
      @(negedge ctrl_clk);
      k++;
    end
    checkOutput("lock_fail_lat", 32'(k), 32'(RST_CYCLES + LOCK_TIMEOUT + 1));
    checkOutput("lock_fail",     32'(cal_fail), 32'd1);
    waitIdle("lock");
    checkOutput("lock_psen", 32'(inc_cnt - run_inc), 32'd0);
    force_unlock = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
